// File: rtl/manchester_pkg.sv
// Shared types and line-coding constants for the Manchester transmitter.
// The PARITY state exists only when MANCHESTER_TX_PARITY_EN is defined.
package manchester_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
`ifdef MANCHESTER_TX_PARITY_EN
        PAYLOAD,
        PARITY
`else
        PAYLOAD
`endif
    } state_e;

    localparam int PAYLOAD_BYTES = 4;
    localparam int PAYLOAD_BITS  = PAYLOAD_BYTES * 8;

    // IEEE 802.3 convention: a 1 is low-then-high, a 0 is high-then-low.
    localparam logic FIRST_HALF_ONE  = 1'b0;
    localparam logic FIRST_HALF_ZERO = 1'b1;
    localparam logic IDLE_LEVEL      = 1'b0;

    function automatic logic first_half_level(input logic b);
        return b ? FIRST_HALF_ONE : FIRST_HALF_ZERO;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/manchester_bit_encoder.sv
// Encodes one presented bit at a time into two half-bit line levels and
// reports bit_done_o in the last cycle of each bit so the next can be loaded.
module manchester_bit_encoder
    import manchester_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic bit_i,
    output logic tx_o,
    output logic strobe_o,
    output logic bit_done_o
);

    localparam int HW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CYCLES - 1);

    logic          active_q;
    logic          half_q;
    logic          bit_q;
    logic          tx_q;
    logic          strobe_q;
    logic [HW-1:0] half_cnt_q;
    logic          half_end;

    assign half_end   = active_q && (half_cnt_q == HALF_LAST);
    assign bit_done_o = half_end && half_q;
    assign tx_o       = tx_q;
    assign strobe_o   = strobe_q;

    // A load at the end of a bit chains straight into the next bit with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            half_q     <= 1'b0;
            bit_q      <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            strobe_q   <= 1'b0;
            half_cnt_q <= '0;
        end else begin
            strobe_q <= 1'b0;
            if (load_i && (!active_q || bit_done_o)) begin
                active_q   <= 1'b1;
                half_q     <= 1'b0;
                half_cnt_q <= '0;
                bit_q      <= bit_i;
                tx_q       <= first_half_level(bit_i);
            end else if (bit_done_o) begin
                active_q   <= 1'b0;
                half_q     <= 1'b0;
                half_cnt_q <= '0;
                tx_q       <= IDLE_LEVEL;
            end else if (half_end) begin
                half_q     <= 1'b1;
                half_cnt_q <= '0;
                tx_q       <= ~first_half_level(bit_q);
                strobe_q   <= 1'b1;
            end else if (active_q) begin
                half_cnt_q <= half_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/manchester_tx.sv
// Manchester frame transmitter: preamble then 4-byte payload, MSB-first.
// Define MANCHESTER_TX_PARITY_EN to append an even-parity bit after the payload.
module manchester_tx
    import manchester_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = 16,
    parameter int PREAMBLE_BITS   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic       tx_out,
    output logic       bit_strobe,
    output logic       busy,
    output logic       done
);

    localparam int MAX_BITS = max_int(PREAMBLE_BITS, PAYLOAD_BITS);
    localparam int CNT_W    = $clog2(MAX_BITS);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BITS - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_BITS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0] payload_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    bit_done;
    logic                    load;
    logic                    next_bit;
    logic [4:0]              wr_msb;
    logic [4:0]              pay_idx;

    // Byte 0 occupies the top of the vector so a simple down-count index gives MSB-first order.
    assign wr_msb  = 5'd31 - {wr_addr, 3'b000};
    assign pay_idx = 5'd31 - bit_cnt_d[4:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q <= '0;
        end else if (wr_en && (state_q == IDLE)) begin
            payload_q[wr_msb -: 8] <= wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = PREAMBLE;
                    bit_cnt_d = '0;
                end
            end
            PREAMBLE: begin
                if (bit_done) begin
                    if (bit_cnt_q == PRE_LAST) begin
                        state_d   = PAYLOAD;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (bit_done) begin
                    if (bit_cnt_q == PAY_LAST) begin
`ifdef MANCHESTER_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = IDLE;
`endif
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef MANCHESTER_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            end
`endif
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // The bit to load is chosen from the next phase/index so payload is read at its first bit.
    always_comb begin
        next_bit = 1'b0;
        case (state_d)
            PREAMBLE: next_bit = ~bit_cnt_d[0];
            PAYLOAD:  next_bit = payload_q[pay_idx];
`ifdef MANCHESTER_TX_PARITY_EN
            PARITY:   next_bit = ^payload_q;
`endif
            default:  next_bit = 1'b0;
        endcase
    end

    assign load = (state_d != IDLE) && ((state_q == IDLE) || bit_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_q != IDLE) && (state_d == IDLE);
        end
    end

    manchester_bit_encoder #(
        .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
    ) u_encoder (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .bit_i     (next_bit),
        .tx_o      (tx_out),
        .strobe_o  (bit_strobe),
        .bit_done_o(bit_done)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_manchester_tx.sv
// Directed bench for manchester_tx with HALF_BIT_CYCLES=4, PREAMBLE_BITS=8.
// Frames are captured one sample per cycle at the falling edge and decoded here.
module tb_manchester_tx;

    localparam int H   = 4;
    localparam int PRE = 8;
`ifdef MANCHESTER_TX_PARITY_EN
    localparam int FRAME_BITS = PRE + 33;
`else
    localparam int FRAME_BITS = PRE + 32;
`endif
    localparam int FRAME_CYC = FRAME_BITS * 2 * H;
    localparam int MAX_CYC   = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic       start = 1'b0;
    logic       tx_out;
    logic       bit_strobe;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic tx_log     [0:MAX_CYC-1];
    logic strobe_log [0:MAX_CYC-1];
    int   busy_len;
    int   done_in_frame;
    int   inj_cycle = -1;

    manchester_tx #(
        .HALF_BIT_CYCLES(H),
        .PREAMBLE_BITS  (PRE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .tx_out    (tx_out),
        .bit_strobe(bit_strobe),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic exp_bit(input int k, input logic [31:0] p);
        if (k < PRE)       return (k % 2 == 0);
        if (k < PRE + 32)  return p[31 - (k - PRE)];
        return ^p;
    endfunction

    function automatic int bit_errors(input logic [31:0] p);
        int e = 0;
        for (int k = 0; k < FRAME_BITS; k++)
            if (tx_log[2*H*k + H] !== exp_bit(k, p)) e++;
        return e;
    endfunction

    // Each bit must hold a constant level per half and invert at mid-bit.
    function automatic int shape_errors();
        int e = 0;
        for (int k = 0; k < FRAME_BITS; k++)
            for (int c = 0; c < 2*H; c++)
                if (tx_log[2*H*k + c] !== ((c < H) ? ~exp_bit(k, 32'h0) : exp_bit(k, 32'h0))
                    && k < PRE) e++;
        for (int k = 0; k < FRAME_BITS; k++)
            for (int c = 0; c < H; c++)
                if (tx_log[2*H*k + c] !== ~tx_log[2*H*k + H + c]) e++;
        return e;
    endfunction

    task automatic write_byte(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_payload(input logic [31:0] p);
        write_byte(2'd0, p[31:24]);
        write_byte(2'd1, p[23:16]);
        write_byte(2'd2, p[15:8]);
        write_byte(2'd3, p[7:0]);
    endtask

    task automatic capture_frame();
        int cyc = 0;
        done_in_frame = 0;
        while (busy === 1'b1 && cyc < MAX_CYC) begin
            tx_log[cyc]     = tx_out;
            strobe_log[cyc] = bit_strobe;
            if (done !== 1'b0) done_in_frame++;
            if (cyc == inj_cycle) begin
                wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h11; start = 1'b1;
            end
            @(negedge clk);
            wr_en = 1'b0; start = 1'b0;
            cyc++;
        end
        busy_len = cyc;
        if (cyc >= MAX_CYC) begin
            total++; bad++;
            $display("[TB] FAIL frame_timeout: busy still high after %0d cycles, want low by %0d", cyc, FRAME_CYC);
        end
    endtask

    task automatic send_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        capture_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (tx_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx: got %b want 0", tx_out); end
        total++; if (bit_strobe !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobe: got %b want 0", bit_strobe); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || tx_out !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset: got busy=%b tx=%b want 0/0", busy, tx_out); end
    endtask

    task automatic test_basic_frame();
        int e;
        write_payload(32'hA53CFF00);
        send_frame();
        total++; if (busy_len !== FRAME_CYC) begin bad++; $display("[TB] FAIL basic_busy_len: got %0d want %0d", busy_len, FRAME_CYC); end
        total++; if (done_in_frame !== 0) begin bad++; $display("[TB] FAIL basic_done_overlap: got %0d want 0", done_in_frame); end
        e = bit_errors(32'hA53CFF00);
        total++; if (e !== 0) begin bad++; $display("[TB] FAIL basic_bits: got %0d wrong bits want 0", e); end
        e = shape_errors();
        total++; if (e !== 0) begin bad++; $display("[TB] FAIL basic_shape: got %0d bad samples want 0", e); end
        total++; if (done !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_done_cycle: got done=%b busy=%b tx=%b want 1/0/0", done, busy, tx_out);
        end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_width: got %b want 0", done); end
    endtask

    task automatic test_line_coding();
        logic [7:0] first;
        int e = 0;
        int strobes = 0;
        int serr = 0;
        write_payload(32'h80000000);
        send_frame();
        for (int c = 0; c < 2*H; c++) first[2*H-1-c] = tx_log[PRE*2*H + c];
        total++; if (first !== 8'b0000_1111) begin bad++; $display("[TB] FAIL line_first_bit: got %b want 00001111", first); end
        for (int k = PRE + 1; k < PRE + 32; k++)
            for (int c = 0; c < 2*H; c++)
                if (tx_log[2*H*k + c] !== ((c < H) ? 1'b1 : 1'b0)) e++;
        total++; if (e !== 0) begin bad++; $display("[TB] FAIL line_zero_bits: got %0d bad samples want 0", e); end
        for (int c = 0; c < busy_len; c++) begin
            if (strobe_log[c] === 1'b1) strobes++;
            if (strobe_log[c] !== ((c % (2*H)) == H)) serr++;
            if (strobe_log[c] === 1'b1 && c > 0 && tx_log[c] === tx_log[c-1]) serr++;
        end
        total++; if (strobes !== FRAME_BITS) begin bad++; $display("[TB] FAIL line_strobe_count: got %0d want %0d", strobes, FRAME_BITS); end
        total++; if (serr !== 0) begin bad++; $display("[TB] FAIL line_strobe_align: got %0d misaligned want 0", serr); end
        @(negedge clk);
    endtask

    task automatic test_blocked();
        int e;
        write_payload(32'hA53CFF00);
        inj_cycle = 50;
        send_frame();
        inj_cycle = -1;
        total++; if (busy_len !== FRAME_CYC) begin bad++; $display("[TB] FAIL blocked_busy_len: got %0d want %0d", busy_len, FRAME_CYC); end
        e = bit_errors(32'hA53CFF00);
        total++; if (e !== 0) begin bad++; $display("[TB] FAIL blocked_bits: got %0d wrong bits want 0", e); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL blocked_start_queued: got busy=%b want 0", busy); end
        send_frame();
        e = bit_errors(32'hA53CFF00);
        total++; if (e !== 0) begin bad++; $display("[TB] FAIL blocked_byte2_kept: got %0d wrong bits want 0", e); end
        @(negedge clk);
    endtask

    task automatic test_start_with_write();
        int e;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h5A; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        capture_frame();
        e = bit_errors(32'h5A3CFF00);
        total++; if (e !== 0) begin bad++; $display("[TB] FAIL start_write_bits: got %0d wrong bits want 0", e); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int e;
        send_frame();
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done: got %b want 1", done); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_restart: got busy=%b want 1", busy); end
        capture_frame();
        total++; if (busy_len !== FRAME_CYC) begin bad++; $display("[TB] FAIL b2b_busy_len: got %0d want %0d", busy_len, FRAME_CYC); end
        e = bit_errors(32'h5A3CFF00);
        total++; if (e !== 0) begin bad++; $display("[TB] FAIL b2b_bits: got %0d wrong bits want 0", e); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int e;
        int dcount = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_pre_busy: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (tx_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bit_strobe !== 1'b0) begin
            bad++; $display("[TB] FAIL abort_async: got tx=%b busy=%b done=%b strobe=%b want 0/0/0/0", tx_out, busy, done, bit_strobe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            if (done !== 1'b0) dcount++;
            @(negedge clk);
        end
        total++; if (dcount !== 0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d done cycles want 0", dcount); end
        send_frame();
        e = bit_errors(32'h00000000);
        total++; if (e !== 0) begin bad++; $display("[TB] FAIL abort_payload_cleared: got %0d wrong bits want 0", e); end
        @(negedge clk);
    endtask

`ifdef MANCHESTER_TX_PARITY_EN
    task automatic test_parity();
        write_payload(32'h01000000);
        send_frame();
        total++; if (busy_len !== 328) begin bad++; $display("[TB] FAIL parity_busy_len: got %0d want 328", busy_len); end
        total++; if (tx_log[(PRE+32)*2*H + H] !== 1'b1) begin bad++; $display("[TB] FAIL parity_odd: got %b want 1", tx_log[(PRE+32)*2*H + H]); end
        @(negedge clk);
        write_payload(32'h03000000);
        send_frame();
        total++; if (tx_log[(PRE+32)*2*H + H] !== 1'b0) begin bad++; $display("[TB] FAIL parity_even: got %b want 0", tx_log[(PRE+32)*2*H + H]); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_line_coding();
        test_blocked();
        test_start_with_write();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef MANCHESTER_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
